// File: rtl/pipe_pkg.sv
// Shared types and RV32I opcode constants for the pipeline controller and decoder.
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        DRAIN    = 2'd2,
        TRAP     = 2'd3
    } ctrl_state_e;

    typedef enum logic [1:0] {
        FWD_RF    = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

    typedef enum logic [1:0] {
        PC_PLUS4 = 2'd0,
        PC_EX    = 2'd1,
        PC_TRAP  = 2'd2
    } pc_sel_e;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

endpackage

// File: rtl/hazard_detect.sv
// RAW / load-use comparator for the instruction in ID; forwarding selects when
// PIPE_CTRL_FWD_EN is defined, otherwise every RAW match becomes a stall.
module hazard_detect
    import pipe_pkg::*;
#(
    parameter int unsigned REGW = 5
) (
    input  logic [REGW-1:0] id_rs1,
    input  logic [REGW-1:0] id_rs2,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic            v_ex,
    input  logic            v_mem,
    input  logic            v_wb,
    input  logic [REGW-1:0] ex_rd,
    input  logic [REGW-1:0] mem_rd,
    input  logic [REGW-1:0] wb_rd,
    input  logic            ex_we,
    input  logic            mem_we,
    input  logic            wb_we,
    input  logic            ex_is_load,
    output logic            load_use,
    output logic            raw_stall,
    output fwd_sel_e        fwd_a,
    output fwd_sel_e        fwd_b
);

    // A producer only counts if it is a live writer of a non-x0 register.
    function automatic logic hit(input logic [REGW-1:0] rs, input logic use_rs,
                                 input logic v, input logic we, input logic [REGW-1:0] rd);
        return use_rs & v & we & (rd != '0) & (rs == rd);
    endfunction

    logic ex_a, ex_b, mem_a, mem_b, wb_a, wb_b;

    assign ex_a  = hit(id_rs1, id_use_rs1, v_ex,  ex_we,  ex_rd);
    assign ex_b  = hit(id_rs2, id_use_rs2, v_ex,  ex_we,  ex_rd);
    assign mem_a = hit(id_rs1, id_use_rs1, v_mem, mem_we, mem_rd);
    assign mem_b = hit(id_rs2, id_use_rs2, v_mem, mem_we, mem_rd);
    assign wb_a  = hit(id_rs1, id_use_rs1, v_wb,  wb_we,  wb_rd);
    assign wb_b  = hit(id_rs2, id_use_rs2, v_wb,  wb_we,  wb_rd);

    assign load_use = ex_is_load & (ex_a | ex_b);

`ifdef PIPE_CTRL_FWD_EN
    // WB needs no path: the register file writes before ID reads it.
    assign raw_stall = 1'b0;
    assign fwd_a = ex_a ? FWD_EXMEM : (mem_a ? FWD_MEMWB : FWD_RF);
    assign fwd_b = ex_b ? FWD_EXMEM : (mem_b ? FWD_MEMWB : FWD_RF);
`else
    assign raw_stall = ex_a | ex_b | mem_a | mem_b | wb_a | wb_b;
    assign fwd_a = FWD_RF;
    assign fwd_b = FWD_RF;
`endif

endmodule

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline sequencer: valid bits, stall/flush/PC-select and trap entry.
// Operand forwarding is enabled by defining PIPE_CTRL_FWD_EN.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned REGW = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    input  logic [REGW-1:0] id_rs1,
    input  logic [REGW-1:0] id_rs2,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic            id_is_sys,
    input  logic [REGW-1:0] ex_rd,
    input  logic [REGW-1:0] mem_rd,
    input  logic [REGW-1:0] wb_rd,
    input  logic            ex_we,
    input  logic            mem_we,
    input  logic            wb_we,
    input  logic            ex_is_load,
    input  logic            ex_redirect,
    input  logic            mem_req,
    input  logic            mem_ready,
    output logic            v_id,
    output logic            v_ex,
    output logic            v_mem,
    output logic            v_wb,
    output logic            if_stall,
    output logic            id_stall,
    output logic            ex_bubble,
    output logic            id_flush,
    output logic            freeze,
    output logic [1:0]      pc_sel,
    output logic            trap_req,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b,
    output logic [XLEN-1:0] stall_cnt
);

    ctrl_state_e state;
    logic        load_use, raw_stall;
    fwd_sel_e    fwd_a_hd, fwd_b_hd;

    hazard_detect #(.REGW(REGW)) u_hazard (
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .v_ex       (v_ex),
        .v_mem      (v_mem),
        .v_wb       (v_wb),
        .ex_rd      (ex_rd),
        .mem_rd     (mem_rd),
        .wb_rd      (wb_rd),
        .ex_we      (ex_we),
        .mem_we     (mem_we),
        .wb_we      (wb_we),
        .ex_is_load (ex_is_load),
        .load_use   (load_use),
        .raw_stall  (raw_stall),
        .fwd_a      (fwd_a_hd),
        .fwd_b      (fwd_b_hd)
    );

    // The release cycle of MEM_WAIT is an ordinary flowing cycle, same as RUN.
    logic run_like, mem_busy, pipe_empty, sys_hold, hazard;

    assign run_like   = (state == RUN) | (state == MEM_WAIT);
    assign mem_busy   = (state == MEM_WAIT) ? ~mem_ready : (v_mem & mem_req & ~mem_ready);
    assign pipe_empty = ~v_ex & ~v_mem & ~v_wb;
    assign sys_hold   = run_like & v_id & id_is_sys;
    assign hazard     = v_id & (load_use | raw_stall);

    assign fwd_a = rst ? 2'(FWD_RF) : 2'(fwd_a_hd);
    assign fwd_b = rst ? 2'(FWD_RF) : 2'(fwd_b_hd);

    // Event priority: freeze, redirect, trap, then drain/hazard stalls.
    always_comb begin
        if_stall  = 1'b0;
        id_stall  = 1'b0;
        ex_bubble = 1'b0;
        id_flush  = 1'b0;
        freeze    = 1'b0;
        trap_req  = 1'b0;
        pc_sel    = 2'(PC_PLUS4);
        if (rst) begin
            id_flush  = 1'b1;
            ex_bubble = 1'b1;
        end else if (mem_busy) begin
            freeze = 1'b1;
        end else if (ex_redirect) begin
            pc_sel    = 2'(PC_EX);
            id_flush  = 1'b1;
            ex_bubble = 1'b1;
        end else if (state == TRAP) begin
            pc_sel    = 2'(PC_TRAP);
            trap_req  = 1'b1;
            id_flush  = 1'b1;
            ex_bubble = 1'b1;
        end else if ((state == DRAIN) | sys_hold | hazard) begin
            if_stall  = 1'b1;
            id_stall  = 1'b1;
            ex_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            v_id      <= 1'b0;
            v_ex      <= 1'b0;
            v_mem     <= 1'b0;
            v_wb      <= 1'b0;
            stall_cnt <= '0;
        end else begin
            if (if_stall | freeze) stall_cnt <= stall_cnt + XLEN'(1);
            if (!freeze) begin
                v_wb  <= v_mem;
                v_mem <= v_ex;
                v_ex  <= v_id & ~ex_bubble;
                v_id  <= id_stall ? v_id : (if_valid & ~id_flush);
            end
            case (state)
                RUN, MEM_WAIT: begin
                    if (mem_busy)                     state <= MEM_WAIT;
                    else if (sys_hold & ~ex_redirect) state <= DRAIN;
                    else                              state <= RUN;
                end
                DRAIN: begin
                    if (!mem_busy) begin
                        if (ex_redirect)     state <= RUN;
                        else if (pipe_empty) state <= TRAP;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed and randomized check of pipe_ctrl against a cycle-level reference model.
module tb_pipe_ctrl;

    localparam int unsigned XLEN = 32;
    localparam int unsigned REGW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, if_valid, id_use_rs1, id_use_rs2, id_is_sys;
    logic [REGW-1:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
    logic            ex_we, mem_we, wb_we, ex_is_load, ex_redirect, mem_req, mem_ready;
    logic            v_id, v_ex, v_mem, v_wb, if_stall, id_stall, ex_bubble, id_flush;
    logic            freeze, trap_req;
    logic [1:0]      pc_sel, fwd_a, fwd_b;
    logic [XLEN-1:0] stall_cnt;

    pipe_ctrl #(.XLEN(XLEN), .REGW(REGW)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_is_sys(id_is_sys), .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .ex_we(ex_we), .mem_we(mem_we), .wb_we(wb_we), .ex_is_load(ex_is_load),
        .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_ready(mem_ready),
        .v_id(v_id), .v_ex(v_ex), .v_mem(v_mem), .v_wb(v_wb),
        .if_stall(if_stall), .id_stall(id_stall), .ex_bubble(ex_bubble), .id_flush(id_flush),
        .freeze(freeze), .pc_sel(pc_sel), .trap_req(trap_req),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: stage occupancy, stall count, and the two pending trap phases.
    logic            m_id, m_ex, m_mem, m_wb, m_drain, m_trap;
    logic [XLEN-1:0] m_cnt;
    logic            e_if_stall, e_id_stall, e_bubble, e_flush, e_freeze, e_trap;
    logic [1:0]      e_pc, e_fwd_a, e_fwd_b;

    function automatic logic hit(input logic [REGW-1:0] rs, input logic u, input logic v,
                                 input logic we, input logic [REGW-1:0] rd);
        return u && v && we && (rd != 0) && (rs == rd);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic eval_model();
        logic ea, eb, ma, mb, wa, wb, hz;
        ea = hit(id_rs1, id_use_rs1, m_ex, ex_we, ex_rd);
        eb = hit(id_rs2, id_use_rs2, m_ex, ex_we, ex_rd);
        ma = hit(id_rs1, id_use_rs1, m_mem, mem_we, mem_rd);
        mb = hit(id_rs2, id_use_rs2, m_mem, mem_we, mem_rd);
        wa = hit(id_rs1, id_use_rs1, m_wb, wb_we, wb_rd);
        wb = hit(id_rs2, id_use_rs2, m_wb, wb_we, wb_rd);
`ifdef PIPE_CTRL_FWD_EN
        hz = ex_is_load && (ea || eb);
        e_fwd_a = ea ? 2'd1 : (ma ? 2'd2 : 2'd0);
        e_fwd_b = eb ? 2'd1 : (mb ? 2'd2 : 2'd0);
`else
        hz = ea || eb || ma || mb || wa || wb;
        e_fwd_a = 2'd0;
        e_fwd_b = 2'd0;
`endif
        e_if_stall = 0; e_id_stall = 0; e_bubble = 0; e_flush = 0;
        e_freeze = 0; e_trap = 0; e_pc = 2'd0;
        if (rst) begin
            e_flush = 1; e_bubble = 1; e_fwd_a = 2'd0; e_fwd_b = 2'd0;
        end else if (m_mem && mem_req && !mem_ready) begin
            e_freeze = 1;
        end else if (ex_redirect) begin
            e_pc = 2'd1; e_flush = 1; e_bubble = 1;
        end else if (m_trap) begin
            e_pc = 2'd2; e_trap = 1; e_flush = 1; e_bubble = 1;
        end else if (m_drain || (m_id && id_is_sys) || (m_id && hz)) begin
            e_if_stall = 1; e_id_stall = 1; e_bubble = 1;
        end
    endtask

    task automatic update_model();
        logic empty, n_drain, n_trap;
        if (rst) begin
            {m_id, m_ex, m_mem, m_wb, m_drain, m_trap} = '0;
            m_cnt = '0;
        end else begin
            if (e_if_stall || e_freeze) m_cnt = m_cnt + 1;
            if (!e_freeze) begin
                empty   = !m_ex && !m_mem && !m_wb;
                n_trap  = m_drain && !ex_redirect && empty;
                n_drain = m_drain ? (!ex_redirect && !empty)
                                  : (!m_trap && m_id && id_is_sys && !ex_redirect);
                m_wb    = m_mem;
                m_mem   = m_ex;
                m_ex    = m_id && !e_bubble;
                m_id    = e_id_stall ? m_id : (if_valid && !e_flush);
                m_drain = n_drain;
                m_trap  = n_trap;
            end
        end
    endtask

    // One clock: compare every output against the model, advance the model, return at negedge.
    task automatic tick();
        #1;
        eval_model();
        check("v_id", 32'(v_id), 32'(m_id));
        check("v_ex", 32'(v_ex), 32'(m_ex));
        check("v_mem", 32'(v_mem), 32'(m_mem));
        check("v_wb", 32'(v_wb), 32'(m_wb));
        check("if_stall", 32'(if_stall), 32'(e_if_stall));
        check("id_stall", 32'(id_stall), 32'(e_id_stall));
        check("ex_bubble", 32'(ex_bubble), 32'(e_bubble));
        check("id_flush", 32'(id_flush), 32'(e_flush));
        check("freeze", 32'(freeze), 32'(e_freeze));
        check("pc_sel", 32'(pc_sel), 32'(e_pc));
        check("trap_req", 32'(trap_req), 32'(e_trap));
        check("fwd_a", 32'(fwd_a), 32'(e_fwd_a));
        check("fwd_b", 32'(fwd_b), 32'(e_fwd_b));
        check("stall_cnt", stall_cnt, m_cnt);
        update_model();
        @(negedge clk);
    endtask

    task automatic neutral();
        rst = 0; if_valid = 0; id_is_sys = 0;
        id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_rd = 5'd10; mem_rd = 5'd11; wb_rd = 5'd12;
        ex_we = 0; mem_we = 0; wb_we = 0; ex_is_load = 0;
        ex_redirect = 0; mem_req = 0; mem_ready = 1;
    endtask

    logic [XLEN-1:0] cnt0;
    logic            prev_frz;

    initial begin
        neutral();
        rst = 1;
        {m_id, m_ex, m_mem, m_wb, m_drain, m_trap} = '0;
        m_cnt = '0;
        repeat (2) @(negedge clk);

        // Reset values
        #1;
        check("rst_v_id", 32'(v_id), 32'd0);
        check("rst_flush", 32'(id_flush), 32'd1);
        check("rst_bubble", 32'(ex_bubble), 32'd1);
        check("rst_cnt", stall_cnt, 32'd0);
        tick();

        // Load-use on x5
        neutral(); if_valid = 1;
        repeat (4) tick();
        id_rs1 = 5'd5; id_use_rs1 = 1; ex_rd = 5'd5; ex_we = 1; ex_is_load = 1;
        #1;
        check("lu_if_stall", 32'(if_stall), 32'd1);
        check("lu_bubble", 32'(ex_bubble), 32'd1);
        tick();
        ex_is_load = 0; ex_we = 0; ex_rd = 5'd10; mem_rd = 5'd5; mem_we = 1;
        #1;
`ifdef PIPE_CTRL_FWD_EN
        check("lu_fwd_a", 32'(fwd_a), 32'd2);
        check("lu_released", 32'(if_stall), 32'd0);
`else
        check("lu_raw_stall", 32'(if_stall), 32'd1);
`endif
        tick();

        // Redirect coinciding with load-use
        neutral(); if_valid = 1;
        repeat (2) tick();
        id_rs1 = 5'd5; id_use_rs1 = 1; ex_rd = 5'd5; ex_we = 1; ex_is_load = 1; ex_redirect = 1;
        #1;
        check("rd_pc_sel", 32'(pc_sel), 32'd1);
        check("rd_flush", 32'(id_flush), 32'd1);
        check("rd_no_stall", 32'(if_stall), 32'd0);
        tick();
        neutral();
        #1;
        check("rd_v_id", 32'(v_id), 32'd0);
        check("rd_v_ex", 32'(v_ex), 32'd0);

        // Memory wait for three cycles
        if_valid = 1;
        repeat (3) tick();
        cnt0 = m_cnt;
        mem_req = 1; mem_ready = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("mw_freeze", 32'(freeze), 32'd1);
            tick();
        end
        mem_ready = 1;
        #1;
        check("mw_release", 32'(freeze), 32'd0);
        check("mw_cnt", stall_cnt, cnt0 + 32'd3);
        check("mw_v_mem", 32'(v_mem), 32'd1);
        tick();

        // ecall with a full pipe: enter, three drain cycles, one trap cycle
        neutral(); if_valid = 1;
        repeat (4) tick();
        id_is_sys = 1;
        for (int k = 0; k < 6; k++) begin
            #1;
            check("sys_trap_req", 32'(trap_req), (k == 4) ? 32'd1 : 32'd0);
            if (k == 4) check("sys_pc_sel", 32'(pc_sel), 32'd2);
            tick();
        end
        id_is_sys = 0;

        // x0 writer in EX never causes a hazard
        neutral(); if_valid = 1;
        repeat (2) tick();
        ex_rd = '0; ex_we = 1; ex_is_load = 1; id_rs1 = '0; id_use_rs1 = 1;
        #1;
        check("x0_no_stall", 32'(if_stall), 32'd0);
        check("x0_fwd_a", 32'(fwd_a), 32'd0);
        tick();

        // Reset in the middle of a drain
        neutral(); if_valid = 1;
        repeat (4) tick();
        id_is_sys = 1;
        repeat (2) tick();
        rst = 1;
        tick();
        neutral();
        #1;
        check("rd_mid_v_mem", 32'(v_mem), 32'd0);
        check("rd_mid_cnt", stall_cnt, 32'd0);
        for (int k = 0; k < 5; k++) begin
            #1;
            check("rd_mid_no_trap", 32'(trap_req), 32'd0);
            tick();
        end

        // Randomized traffic; memory keeps its request up while stalled
        prev_frz = 0;
        for (int i = 0; i < 800; i++) begin
            rst        = ($urandom_range(0, 99) == 0);
            if_valid   = ($urandom_range(0, 3) != 0);
            id_rs1     = REGW'($urandom_range(0, 3));
            id_rs2     = REGW'($urandom_range(0, 3));
            id_use_rs1 = ($urandom_range(0, 1) == 1);
            id_use_rs2 = ($urandom_range(0, 1) == 1);
            id_is_sys  = ($urandom_range(0, 15) == 0);
            ex_rd      = REGW'($urandom_range(0, 3));
            mem_rd     = REGW'($urandom_range(0, 3));
            wb_rd      = REGW'($urandom_range(0, 3));
            ex_we      = ($urandom_range(0, 1) == 1);
            mem_we     = ($urandom_range(0, 1) == 1);
            wb_we      = ($urandom_range(0, 1) == 1);
            ex_is_load = ($urandom_range(0, 2) == 0);
            ex_redirect = m_ex && ($urandom_range(0, 7) == 0);
            mem_req    = prev_frz || (m_mem && ($urandom_range(0, 1) == 1));
            mem_ready  = ($urandom_range(0, 2) != 0);
            tick();
            prev_frz = e_freeze;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
